// File: rtl/bcnt_pkg.sv
// Shared constants and helpers for the cascadable up/down counter built from 4-bit stages.
package bcnt_pkg;
    localparam int NIB_W = 4;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Terminal nibble: the value a stage must show before it passes a carry/borrow upward.
    function automatic logic [NIB_W-1:0] term_nib(input logic dir);
        return (dir == DIR_UP) ? 4'hF : 4'h0;
    endfunction
endpackage

// File: rtl/bcnt4_stage.sv
// One 4-bit up/down counter stage: clear beats load beats count; tc4 flags the terminal nibble.
module bcnt4_stage
    import bcnt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_n,
    input  logic             ld,
    input  logic             cin,
    input  logic             dir,
    input  logic [NIB_W-1:0] d4,
    output logic [NIB_W-1:0] q4,
    output logic             tc4
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q4 <= '0;
        end else if (!clr_n) begin
            q4 <= '0;
        end else if (ld) begin
            q4 <= d4;
        end else if (cin) begin
            q4 <= (dir == DIR_UP) ? q4 + 4'd1 : q4 - 4'd1;
        end
    end

    assign tc4 = (q4 == term_nib(dir));
endmodule

// File: rtl/bcnt163_updn.sv
// Cascadable up/down binary counter: NIB 4-bit stages, sync clear/load, dual enables,
// optional modulo-N auto-reload, combinational rco and a registered terminal-step pulse.
module bcnt163_updn
    import bcnt_pkg::*;
#(
    parameter int NIB = 2,
    localparam int W = NIB_W * NIB
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_n,
    input  logic         ld_n,
    input  logic [W-1:0] d,
    input  logic         en_p,
    input  logic         en_t,
    input  logic         dir,
    input  logic         reload,
    output logic [W-1:0] q,
    output logic         rco,
    output logic         wrap
);
    logic           step;
    logic           at_tv;
    logic           reload_hit;
    logic           ld_all;
    logic [NIB-1:0] cin;
    logic [NIB-1:0] tc4;

    assign step       = en_p & en_t;
    assign at_tv      = &tc4;
    assign reload_hit = step & at_tv & reload;
    assign ld_all     = ~ld_n | reload_hit;

    // Stage i advances only when every lower stage sits at its terminal nibble.
    always_comb begin
        cin[0] = step;
        for (int i = 1; i < NIB; i++) begin
            cin[i] = cin[i-1] & tc4[i-1];
        end
    end

    for (genvar g = 0; g < NIB; g++) begin : g_stage
        bcnt4_stage u_stage (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_n (clr_n),
            .ld    (ld_all),
            .cin   (cin[g]),
            .dir   (dir),
            .d4    (d[g*NIB_W +: NIB_W]),
            .q4    (q[g*NIB_W +: NIB_W]),
            .tc4   (tc4[g])
        );
    end

    assign rco = en_t & at_tv;

    // A terminal step (wrap or reload) only counts when clear and load are not overriding it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap <= 1'b0;
        end else begin
            wrap <= clr_n & ld_n & step & at_tv;
        end
    end
endmodule

// File: tb/tb_bcnt163_updn.sv
// Bench for bcnt163_updn: directed scenarios plus random stimulus, two chained instances,
// expectations from an arithmetic reference model queued for a separate monitor.
module tb_bcnt163_updn;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr_n = 1'b1;
    logic         ld_n = 1'b1;
    logic [W-1:0] d = '0;
    logic         en_p = 1'b0;
    logic         en_t = 1'b0;
    logic         dir = 1'b1;
    logic         reload = 1'b0;
    logic [W-1:0] q_a;
    logic         rco_a;
    logic         wrap_a;
    logic [W-1:0] q_b;
    logic         rco_b;
    logic         wrap_b;

    always #5 clk = ~clk;

    bcnt163_updn #(.NIB(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .ld_n(ld_n), .d(d),
        .en_p(en_p), .en_t(en_t), .dir(dir), .reload(reload),
        .q(q_a), .rco(rco_a), .wrap(wrap_a)
    );

    bcnt163_updn #(.NIB(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr_n(clr_n), .ld_n(1'b1), .d(8'h00),
        .en_p(en_p), .en_t(rco_a), .dir(dir), .reload(1'b0),
        .q(q_b), .rco(rco_b), .wrap(wrap_b)
    );

    // {rco_a this cycle, wrap_a after edge, q_b after edge, q_a after edge}
    logic [17:0] exp_q[$];
    int n_vec = 0;
    int n_miss = 0;
    int m_qa = 0;
    int m_qb = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic on integers.
    task automatic apply(input logic c, input logic l, input logic [W-1:0] dv,
                         input logic ep, input logic et, input logic dr, input logic rl);
        int  tv;
        bit  step, at, rco_e, wrap_e, b_step;
        int  na, nb;
        @(negedge clk);
        clr_n = c; ld_n = l; d = dv; en_p = ep; en_t = et; dir = dr; reload = rl;
        tv     = dr ? 255 : 0;
        step   = ep && et;
        at     = (m_qa == tv);
        rco_e  = et && at;
        b_step = ep && rco_e;
        wrap_e = c && l && step && at;
        if (!c)                    na = 0;
        else if (!l)               na = int'(dv);
        else if (step && at && rl) na = int'(dv);
        else if (step)             na = dr ? (m_qa + 1) % 256 : (m_qa + 255) % 256;
        else                       na = m_qa;
        if (!c)          nb = 0;
        else if (b_step) nb = dr ? (m_qb + 1) % 256 : (m_qb + 255) % 256;
        else             nb = m_qb;
        exp_q.push_back({rco_e, wrap_e, nb[7:0], na[7:0]});
        m_qa = na;
        m_qb = nb;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q", q_a, 8'h00);
        chk("async_rst_wrap", {7'd0, wrap_a}, 8'h00);
        chk("async_rst_qb", q_b, 8'h00);
        m_qa = 0;
        m_qb = 0;
        #1 rst_n = 1'b1;
    endtask

    // Monitor: rco sampled late in the low phase, registered outputs just after the edge.
    initial begin
        logic [17:0] it;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                chk("rco", {7'd0, rco_a}, {7'd0, it[17]});
                @(posedge clk);
                #1;
                chk("q", q_a, it[7:0]);
                chk("wrap", {7'd0, wrap_a}, {7'd0, it[16]});
                chk("cascade_q", q_b, it[15:8]);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q", q_a, 8'h00);
        chk("reset_wrap", {7'd0, wrap_a}, 8'h00);
        #2 rst_n = 1'b1;

        // Reset and clear: reach 37, async reset, then clear beats load.
        apply(1, 0, 8'h36, 0, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 1, 1, 0);
        async_reset();
        apply(0, 0, 8'hAA, 1, 1, 1, 0);

        // Up wrap FE -> FF -> 00.
        apply(1, 0, 8'hFE, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) apply(1, 1, 8'h00, 1, 1, 1, 0);

        // Down with nibble borrow 10 -> 0F ... 00 -> FF.
        apply(1, 0, 8'h10, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) apply(1, 1, 8'h00, 1, 1, 0, 0);

        // Enable gating at FF.
        apply(1, 0, 8'hFF, 0, 0, 1, 0);
        apply(1, 1, 8'h00, 0, 1, 1, 0);
        apply(1, 1, 8'h00, 0, 0, 1, 0);
        apply(1, 1, 8'h00, 1, 0, 1, 0);

        // Reload divider, then a new reload value mid-run.
        apply(1, 0, 8'h04, 0, 0, 0, 1);
        for (int i = 0; i < 12; i++) apply(1, 1, 8'h04, 1, 1, 0, 1);
        for (int i = 0; i < 12; i++) apply(1, 1, 8'h02, 1, 1, 0, 1);
        // Reload value equal to terminal value: wrap stays high.
        for (int i = 0; i < 4; i++) apply(1, 1, 8'h00, 1, 1, 0, 1);

        // Cascade: B steps once per 256 A steps.
        apply(0, 1, 8'h00, 0, 0, 1, 0);
        for (int i = 0; i < 520; i++) apply(1, 1, 8'h00, 1, 1, 1, 0);

        // Random stimulus.
        for (int i = 0; i < 3000; i++) begin
            logic [W-1:0] dv;
            dv = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) dv = $urandom_range(0, 1) != 0 ? 8'hFF : 8'h00;
            apply($urandom_range(0, 31) != 0, $urandom_range(0, 15) != 0, dv,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
            if (i == 1500) async_reset();
        end

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
